// File: rtl/packet_arbiter.sv
// Round-robin, packet-atomic arbiter feeding a single FIFO write port.
// A granted source keeps the port until its last beat; overlong packets are cut and drained.
module packet_arbiter #(
    parameter int WIDTH      = 8,
    parameter int PORTS      = 2,
    parameter int MAX_LENGTH = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [PORTS-1:0]       s_valid_i,
    output logic [PORTS-1:0]       s_ready_o,
    input  logic [PORTS-1:0]       s_last_i,
    input  logic [PORTS*WIDTH-1:0] s_data_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic                   m_last_o,
    output logic [WIDTH-1:0]       m_data_o,
    output logic [PORTS-1:0]       grant_o,
    output logic                   trunc_o
);

    localparam int PW = $clog2(PORTS);
    localparam int CW = (MAX_LENGTH > 0) ? $clog2(MAX_LENGTH + 1) : 1;
    localparam logic [CW-1:0] TRUNC_AT = (MAX_LENGTH > 0) ? CW'(MAX_LENGTH - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic [PW-1:0]    prio_q, prio_d;
    logic [CW-1:0]    count_q, count_d;
    logic             trunc_q, trunc_d;

    logic [WIDTH-1:0] masked_data [PORTS];
    logic [WIDTH-1:0] sel_data;
    logic             sel_valid;
    logic             sel_last;
    logic             handshake;
    logic             trunc_beat;

    // First requester strictly after the last winner, wrapping around.
    function automatic logic [PORTS-1:0] rr_pick(input logic [PORTS-1:0] req,
                                                 input logic [PW-1:0]    last);
        logic [PORTS-1:0] pick;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= PORTS; i++) begin
            for (int j = 0; j < PORTS; j++) begin
                if (!found && req[j] && (((int'(last) + i) % PORTS) == j)) begin
                    pick[j] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
        return pick;
    endfunction

    function automatic logic [PW-1:0] onehot_index(input logic [PORTS-1:0] oh);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (oh[i]) begin
                idx = PW'(i);
            end
        end
        return idx;
    endfunction

    // One-hot AND-OR mux: an empty grant yields zero data for free.
    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_mask
            assign masked_data[gi] = s_data_i[gi*WIDTH +: WIDTH] & {WIDTH{grant_q[gi]}};
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < PORTS; i++) begin
            sel_data = sel_data | masked_data[i];
        end
    end

    assign sel_valid = |(s_valid_i & grant_q);
    assign sel_last  = |(s_last_i & grant_q);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        prio_d     = prio_q;
        count_d    = count_q;
        trunc_d    = 1'b0;
        m_valid_o  = 1'b0;
        m_last_o   = 1'b0;
        s_ready_o  = '0;
        handshake  = 1'b0;
        trunc_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (|s_valid_i) begin
                    grant_d = rr_pick(s_valid_i, prio_q);
                    count_d = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                m_valid_o  = sel_valid;
                s_ready_o  = grant_q & {PORTS{m_ready_i}};
                handshake  = sel_valid & m_ready_i;
                trunc_beat = (MAX_LENGTH > 0) && handshake && (count_q == TRUNC_AT) && !sel_last;
                m_last_o   = sel_last | trunc_beat;
                if (handshake) begin
                    count_d = count_q + 1'b1;
                    if (sel_last) begin
                        prio_d  = onehot_index(grant_q);
                        grant_d = '0;
                        state_d = IDLE;
                    end else if (trunc_beat) begin
                        trunc_d = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Swallow the rest of the oversize packet without forwarding it.
                s_ready_o = grant_q;
                if (sel_valid && sel_last) begin
                    prio_d  = onehot_index(grant_q);
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            prio_q  <= PW'(PORTS - 1);
            count_q <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            count_q <= count_d;
            trunc_q <= trunc_d;
        end
    end

    assign m_data_o = sel_data;
    assign grant_o  = grant_q;
    assign trunc_o  = trunc_q;

endmodule

// File: tb/tb_packet_arbiter.sv
// Directed and randomized bench for packet_arbiter (3 ports, 4-beat limit)
// against a cycle-level model built from the arbitration rules.
module tb_packet_arbiter;

    localparam int WIDTH      = 8;
    localparam int PORTS      = 3;
    localparam int MAX_LENGTH = 4;
    localparam int DEPTH      = 64;

    logic                   clock;
    logic                   reset;
    logic [PORTS-1:0]       s_valid;
    logic [PORTS-1:0]       s_ready;
    logic [PORTS-1:0]       s_last;
    logic [PORTS*WIDTH-1:0] s_data;
    logic                   m_valid;
    logic                   m_ready;
    logic                   m_last;
    logic [WIDTH-1:0]       m_data;
    logic [PORTS-1:0]       grant;
    logic                   trunc;

    packet_arbiter #(
        .WIDTH     (WIDTH),
        .PORTS     (PORTS),
        .MAX_LENGTH(MAX_LENGTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .s_valid_i(s_valid),
        .s_ready_o(s_ready),
        .s_last_i (s_last),
        .s_data_i (s_data),
        .m_valid_o(m_valid),
        .m_ready_i(m_ready),
        .m_last_o (m_last),
        .m_data_o (m_data),
        .grant_o  (grant),
        .trunc_o  (trunc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Source-side packet storage
    logic [WIDTH-1:0] mem   [PORTS][DEPTH];
    bit               lastm [PORTS][DEPTH];
    int               rd    [PORTS];
    int               wr    [PORTS];
    bit               held  [PORTS];
    bit               gap_en;
    bit               rand_ready;
    bit               ready_val;

    // Reference model: who owns the port, how far in, and who won last.
    int owner;
    bit draining;
    int beats;
    int last_win;
    bit trunc_exp;

    int gnt_log[$];
    int trunc_log[$];
    int out_data[$];
    int out_last[$];
    int out_port[$];
    int out_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        trunc_log.delete();
        out_data.delete();
        out_last.delete();
        out_port.delete();
        out_cyc.delete();
    endtask

    task automatic send(input int p, input int len, input logic [WIDTH-1:0] base);
        for (int i = 0; i < len; i++) begin
            mem[p][wr[p] % DEPTH]   = base + WIDTH'(i);
            lastm[p][wr[p] % DEPTH] = (i == len - 1);
            wr[p]++;
        end
    endtask

    function automatic int pending();
        int n;
        n = 0;
        for (int p = 0; p < PORTS; p++) n += wr[p] - rd[p];
        return n;
    endfunction

    function automatic int oh_to_int(input logic [PORTS-1:0] oh);
        int r;
        r = -1;
        for (int i = 0; i < PORTS; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        owner     = -1;
        draining  = 1'b0;
        beats     = 0;
        last_win  = PORTS - 1;
        trunc_exp = 1'b0;
    endtask

    task automatic flush_sources();
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        for (int p = 0; p < PORTS; p++) begin
            held[p] = 1'b0;
            rd[p]   = wr[p];
        end
    endtask

    task automatic drive_sources();
        m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_val;
        for (int p = 0; p < PORTS; p++) begin
            if (!held[p]) begin
                if (rd[p] != wr[p] && (!gap_en || $urandom_range(0, 3) != 0)) begin
                    held[p]                  = 1'b1;
                    s_valid[p]               = 1'b1;
                    s_data[p*WIDTH +: WIDTH] = mem[p][rd[p] % DEPTH];
                    s_last[p]                = lastm[p][rd[p] % DEPTH];
                end else begin
                    s_valid[p]               = 1'b0;
                    s_data[p*WIDTH +: WIDTH] = gap_en ? WIDTH'($urandom) : '0;
                    s_last[p]                = gap_en ? 1'($urandom) : 1'b0;
                end
            end
        end
    endtask

    // One clock: drive at edge+1, check mid-cycle, advance model, wait for next edge.
    task automatic tick();
        logic [PORTS-1:0] one;
        logic [PORTS-1:0] exp_ready;
        logic [WIDTH-1:0] exp_data;
        bit sv, sl, exp_valid, exp_last, hs, tb_beat, trunc_next, found;
        drive_sources();
        #4;
        one = '0; exp_ready = '0; exp_data = '0;
        sv = 0; sl = 0; exp_valid = 0; exp_last = 0; hs = 0; tb_beat = 0; trunc_next = 0;
        if (owner >= 0) begin
            one[owner] = 1'b1;
            sv         = s_valid[owner];
            sl         = s_last[owner];
            exp_data   = s_data[owner*WIDTH +: WIDTH];
            if (!draining) begin
                exp_valid = sv;
                exp_ready = m_ready ? one : '0;
                hs        = sv && m_ready;
                tb_beat   = hs && (beats == MAX_LENGTH - 1) && !sl;
                exp_last  = sl || tb_beat;
            end else begin
                exp_ready = one;
            end
        end
        chk("grant", 32'(grant), 32'(one));
        chk("m_valid", 32'(m_valid), 32'(exp_valid));
        chk("s_ready", 32'(s_ready), 32'(exp_ready));
        chk("trunc", 32'(trunc), 32'(trunc_exp));
        if (owner < 0) begin
            chk("idle_data", 32'(m_data), 32'h0);
            chk("idle_last", 32'(m_last), 32'h0);
        end else if (exp_valid) begin
            chk("m_data", 32'(m_data), 32'(exp_data));
            chk("m_last", 32'(m_last), 32'(exp_last));
        end
        gnt_log.push_back(int'(grant));
        trunc_log.push_back(int'(trunc));
        if (m_valid && m_ready) begin
            out_data.push_back(int'(m_data));
            out_last.push_back(int'(m_last));
            out_port.push_back(oh_to_int(grant));
            out_cyc.push_back(cyc);
        end
        for (int p = 0; p < PORTS; p++) begin
            if (s_valid[p] && exp_ready[p]) begin
                held[p] = 1'b0;
                rd[p]++;
            end
        end
        if (owner < 0) begin
            found = 1'b0;
            for (int i = 1; i <= PORTS; i++) begin
                if (!found && s_valid[(last_win + i) % PORTS]) begin
                    owner = (last_win + i) % PORTS;
                    found = 1'b1;
                end
            end
            beats    = 0;
            draining = 1'b0;
        end else if (!draining) begin
            if (hs) begin
                beats++;
                if (sl) begin
                    last_win = owner;
                    owner    = -1;
                end else if (tb_beat) begin
                    draining   = 1'b1;
                    trunc_next = 1'b1;
                end
            end
        end else if (sv && sl) begin
            last_win = owner;
            owner    = -1;
            draining = 1'b0;
        end
        trunc_exp = trunc_next;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        flush_sources();
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
        model_reset();
    endtask

    initial begin
        reset = 1'b0;
        m_ready = 1'b1;
        gap_en = 1'b0; rand_ready = 1'b0; ready_val = 1'b1;
        for (int p = 0; p < PORTS; p++) begin
            rd[p] = 0; wr[p] = 0; held[p] = 1'b0;
        end
        s_valid = '1; s_last = '1; s_data = '1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_m_last", 32'(m_last), 32'h0);
        chk("rst_m_data", 32'(m_data), 32'h0);
        chk("rst_s_ready", 32'(s_ready), 32'h0);
        chk("rst_trunc", 32'(trunc), 32'h0);
        flush_sources();
        #2 reset = 1'b1;
        @(posedge clock);
        #1;

        $display("test1: single 4-beat packet on port 0");
        clear_logs();
        send(0, 4, 8'hA0);
        repeat (8) tick();
        chk("t1_gnt0", 32'(gnt_log[0]), 32'h0);
        chk("t1_gnt1", 32'(gnt_log[1]), 32'h1);
        chk("t1_gnt4", 32'(gnt_log[4]), 32'h1);
        chk("t1_gnt5", 32'(gnt_log[5]), 32'h0);
        chk("t1_beats", 32'(out_data.size()), 32'd4);
        if (out_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_data", 32'(out_data[i]), 32'hA0 + 32'(i));
                chk("t1_last", 32'(out_last[i]), 32'(i == 3));
            end
            chk("t1_consecutive", 32'(out_cyc[3] - out_cyc[0]), 32'd3);
        end

        $display("test2: two ports, 3-beat packets, round robin");
        do_reset();
        clear_logs();
        send(0, 3, 8'h10); send(0, 3, 8'h20);
        send(1, 3, 8'h30); send(1, 3, 8'h40);
        repeat (18) tick();
        chk("t2_gnt1", 32'(gnt_log[1]), 32'h1);
        chk("t2_gnt4", 32'(gnt_log[4]), 32'h0);
        chk("t2_gnt5", 32'(gnt_log[5]), 32'h2);
        chk("t2_gnt8", 32'(gnt_log[8]), 32'h0);
        chk("t2_gnt9", 32'(gnt_log[9]), 32'h1);
        chk("t2_gnt13", 32'(gnt_log[13]), 32'h2);
        chk("t2_beats", 32'(out_data.size()), 32'd12);
        if (out_data.size() == 12) begin
            for (int k = 0; k < 12; k++) begin
                chk("t2_port", 32'(out_port[k]), 32'((k / 3) % 2));
                chk("t2_data", 32'(out_data[k]),
                    32'((((k / 3) % 2 == 0) ? 'h10 : 'h30) + ((k / 3) / 2) * 'h10 + k % 3));
            end
        end

        $display("test3: 6-beat packet truncated to 4");
        clear_logs();
        send(1, 6, 8'h60);
        repeat (10) tick();
        chk("t3_beats", 32'(out_data.size()), 32'd4);
        if (out_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t3_data", 32'(out_data[i]), 32'h60 + 32'(i));
                chk("t3_last", 32'(out_last[i]), 32'(i == 3));
            end
        end
        chk("t3_trunc5", 32'(trunc_log[5]), 32'h1);
        chk("t3_trunc_sum", 32'(trunc_log.sum()), 32'd1);
        chk("t3_drain_gnt", 32'(gnt_log[6]), 32'h2);
        chk("t3_idle_gnt", 32'(gnt_log[7]), 32'h0);
        chk("t3_consumed", 32'(wr[1] - rd[1]), 32'd0);

        $display("test4: back-pressure during 4-beat packet");
        clear_logs();
        send(2, 4, 8'h70);
        for (int i = 0; i < 9; i++) begin
            ready_val = !(i == 2 || i == 3);
            tick();
        end
        ready_val = 1'b1;
        chk("t4_beats", 32'(out_data.size()), 32'd4);
        if (out_data.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t4_data", 32'(out_data[i]), 32'h70 + 32'(i));
            chk("t4_stall_gap", 32'(out_cyc[1] - out_cyc[0]), 32'd3);
        end

        $display("test5: reset mid-packet");
        clear_logs();
        send(0, 1, 8'h80);
        repeat (4) tick();
        send(0, 5, 8'h90);
        repeat (3) tick();
        chk("t5_pre_grant", 32'(grant), 32'h1);
        chk("t5_pre_valid", 32'(m_valid), 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("t5_async_grant", 32'(grant), 32'h0);
        chk("t5_async_valid", 32'(m_valid), 32'h0);
        chk("t5_async_ready", 32'(s_ready), 32'h0);
        chk("t5_async_data", 32'(m_data), 32'h0);
        flush_sources();
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
        model_reset();
        clear_logs();
        send(1, 1, 8'hC0);
        send(0, 1, 8'hB0);
        repeat (6) tick();
        chk("t5_beats", 32'(out_data.size()), 32'd2);
        if (out_data.size() == 2) begin
            chk("t5_first_port", 32'(out_port[0]), 32'h0);
            chk("t5_first_data", 32'(out_data[0]), 32'hB0);
            chk("t5_second_port", 32'(out_port[1]), 32'h1);
        end

        $display("test6: three ports, continuous 1-beat packets");
        do_reset();
        clear_logs();
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < PORTS; p++) send(p, 1, WIDTH'(16 * r + p));
        end
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            chk("t6_grant", 32'(gnt_log[i]), (i % 2 == 0) ? 32'h0 : 32'(1 << ((i / 2) % 3)));
        end

        $display("test7: randomized traffic");
        do_reset();
        clear_logs();
        gap_en = 1'b1;
        rand_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < PORTS; p++) begin
                if (wr[p] - rd[p] < 20) send(p, $urandom_range(1, 7), WIDTH'($urandom));
            end
            tick();
        end
        for (int k = 0; k < 2000 && !(pending() == 0 && owner < 0); k++) tick();
        chk("t7_drained", 32'(pending()), 32'd0);
        chk("t7_truncations_seen", 32'(trunc_log.sum() > 0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_arbiter.md
# packet_arbiter

Round-robin, packet-atomic arbiter that shares the single write port of a `packet_fifo` between `PORTS` AXI-stream-style sources. It sits directly upstream of the FIFO's `valid_i/ready_i/last_i/data_i` port and connects them to `m_*`. Once a source is granted, it holds the port until that source's `last` beat, so packets never interleave. An optional maximum-length check truncates runaway packets and discards their remaining beats.

## Interface

Parameters:
- `WIDTH`, 8, data width in bits.
- `PORTS`, 2, number of sources; legal range 2..8.
- `MAX_LENGTH`, 0, maximum beats per packet; 0 disables truncation.

Ports:
- `clock`  in  1  single system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `s_valid_i`  in  PORTS  per-source valid.
- `s_ready_o`  out  PORTS  per-source ready.
- `s_last_i`  in  PORTS  per-source last beat of packet.
- `s_data_i`  in  PORTS*WIDTH  source data; source k uses bits [k*WIDTH +: WIDTH].
- `m_valid_o`  out  1  valid to the FIFO write port.
- `m_ready_i`  in  1  ready from the FIFO.
- `m_last_o`  out  1  last to the FIFO.
- `m_data_o`  out  WIDTH  data to the FIFO.
- `grant_o`  out  PORTS  one-hot current grant; all zero when idle.
- `trunc_o`  out  1  one-cycle pulse when a packet is truncated.

## Operation

State machine with states IDLE, XFER and DRAIN.

Registers:
- `state`
- `grant` (one-hot)
- `prio`: index of the most recently granted port
- `count`: beats of the current packet, width clog2(MAX_LENGTH+1), minimum 1

IDLE:
- `m_valid_o` = 0 and `s_ready_o` = 0.
- If any `s_valid_i` is high, pick the first requesting port searching upward from `prio+1`, modulo PORTS.
- Register that port as `grant`, clear `count`, go to XFER.

XFER (g = granted index):
- `m_valid_o` = `s_valid_i[g]`.
- `m_data_o` = the data slice of port g.
- `s_ready_o[g]` = `m_ready_i`; all other ready bits are 0.
- `m_last_o` = `s_last_i[g]`, or 1 on a truncation beat.
- Each handshake (`m_valid_o & m_ready_i`) increments `count`.
- Handshake with `s_last_i[g]`: `prio` <= g, `grant` <= 0, go to IDLE.
- Truncation beat (MAX_LENGTH>0, handshake, `count` == MAX_LENGTH-1, `s_last_i[g]`=0):
  - `m_last_o` is forced to 1.
  - `trunc_o` pulses for one cycle on the next cycle.
  - Go to DRAIN.

DRAIN:
- `m_valid_o` = 0 and `s_ready_o[g]` = 1.
- Beats from port g are accepted and discarded.
- `s_valid_i[g] & s_last_i[g]` sets `prio` <= g, `grant` <= 0 and returns to IDLE.

Datapath:
- Combinational mux selected by the registered `grant`.
- Ungranted ports always see ready = 0.
- `m_data_o` is 0 whenever `grant` is 0.

Sources must hold valid, data and last stable until accepted. The arbiter does not check this.

## Timing

Reset values (while `reset` = 0):
- `state` = IDLE, `grant_o` = 0, `prio` = PORTS-1 (so port 0 wins first), `count` = 0, `trunc_o` = 0.
- `m_valid_o`, `m_last_o`, `m_data_o` and `s_ready_o` are all 0.

Latency and throughput:
- A request is sampled in IDLE and `grant_o` appears on the next edge. The first beat can transfer in the cycle after that.
- This gives 1 bubble cycle between packets.
- Inside XFER, one beat per cycle, with zero-cycle combinational pass-through of valid, ready, data and last.

Boundary conditions:
- A request arriving while another port holds the grant waits; it is never preempted.
- Simultaneous requests are resolved by round-robin from `prio+1`.
- A single-beat packet (last on the first beat) gives XFER for one cycle, then IDLE.
- `m_ready_i` low holds state and `count`; there is no timeout.
- MAX_LENGTH = 1: every beat is a truncation beat unless `s_last_i` is high on it.
- A port dropping `s_valid_i` mid-packet keeps the grant.
- `reset` asserted mid-packet:
  - All outputs clear immediately (asynchronous).
  - The FIFO sees an unterminated packet; the FIFO must be reset on the same reset.

## Test plan

- Port 0 sends a 4-byte packet (A0..A3, last on A3) with `m_ready_i`=1 → grant_o=01 one cycle after the request, m_* carries A0..A3 on 4 consecutive cycles, m_last_o only on A3, then IDLE.
- Ports 0 and 1 both request 3-beat packets from reset → port 0 is granted first, then port 1 after one bubble. Both re-request immediately → port 0 is next. No beat interleaving.
- MAX_LENGTH=4, port 1 sends 6 beats → 4 beats forwarded with m_last_o on beat 4, trunc_o pulses once, beats 5 and 6 are accepted with m_valid_o=0, then IDLE.
- `m_ready_i` toggles 1,0,0,1 during a 4-beat packet → `s_ready_o[g]` follows `m_ready_i`, data holds while stalled, exactly 4 handshakes, no duplicate or lost beats.
- `reset` driven low after beat 2 of 5 → grant_o, m_valid_o and s_ready_o go to 0 asynchronously. After release, port 0 has first priority again.
- PORTS=3, all three ports continuously request 1-beat packets → grants cycle 001, 010, 100, 001 with one idle cycle between each.
